// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the unified byte-wide RAM controller:
//   - FSM state encoding (IDLE / READ / WRITE / DONE)
//   - request size codes as presented on mem_sel_i
//   - reset-active level for this block (active-low)
//   - helpers turning a size code into a byte count and a byte count into
//     the zero-extension mask applied to assembled read data
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        MC_IDLE  = 2'b00,
        MC_READ  = 2'b01,
        MC_WRITE = 2'b10,
        MC_DONE  = 2'b11
    } mc_state_e;

    // Access size codes on mem_sel_i (2'b11 is handled as a word)
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    // Level of rst that holds the block in reset
    localparam logic RST_ENABLE = 1'b0;

    // Number of RAM byte cycles for a size code
    function automatic logic [2:0] size_to_count(input logic [1:0] sel);
        logic [2:0] n;
        case (sel)
            MEM_BYTE: n = 3'd1;
            MEM_HALF: n = 3'd2;
            MEM_WORD: n = 3'd4;
            default:  n = 3'd4;
        endcase
        return n;
    endfunction

    // Keeps only the bytes actually fetched; upper bytes read back as zero
    function automatic logic [31:0] size_mask(input logic [2:0] n);
        logic [31:0] m;
        case (n)
            3'd1:    m = 32'h0000_00FF;
            3'd2:    m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
// Arbitrates a single byte-wide RAM port between instruction fetch (IF) and
// the MEM stage. Each 1/2/4-byte request is broken into consecutive RAM byte
// cycles; read bytes are assembled little-endian and zero-extended. A stall
// is raised whenever the controller is busy or a request is waiting.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   if_req_i/addr_i   word fetch request and address
//   if_data_o/done_o  fetched word, one-cycle completion pulse
//   mem_req_i/we_i    data access request, 1=store 0=load
//   mem_sel_i         size 00 byte, 01 half, 10/11 word
//   mem_addr_i        data address
//   mem_wdata_i       store data (low bytes used)
//   mem_rdata_o       load data (zero-extended), valid with mem_done_o
//   mem_done_o        one-cycle completion pulse
//   ram_din_i         RAM read byte, one cycle after its address
//   ram_dout_o        RAM write byte
//   ram_a_o           RAM byte address
//   ram_wr_o          RAM write enable
//   stall_o           pipeline stall request
// ---------------------------------------------------------------------------
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_done_o,
    input  logic [7:0]        ram_din_i,
    output logic [7:0]        ram_dout_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o,
    output logic              stall_o
);

    mc_state_e         state_r;
    logic              owner_mem_r;   // 1: MEM stage owns the access, 0: IF
    logic [ADDR_W-1:0] addr_r;
    logic [2:0]        cnt_n_r;       // bytes in this access (1/2/4)
    logic [2:0]        k_r;           // current byte cycle
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] buf_r;

    logic [2:0]        k_inc_s;
    logic [1:0]        k_dec_s;
    logic [ADDR_W-1:0] addr_next_s;
    logic [7:0]        wbyte_next_s;
    logic [DATA_W-1:0] final_buf_s;
    logic [DATA_W-1:0] read_data_s;

    // Next-cycle address/data and the read buffer with the byte arriving now merged in
    always_comb begin
        k_inc_s      = k_r + 3'd1;
        k_dec_s      = k_r[1:0] - 2'd1;
        addr_next_s  = addr_r + {{(ADDR_W-3){1'b0}}, k_inc_s};
        wbyte_next_s = wdata_r[{k_inc_s[1:0], 3'b000} +: 8];
        final_buf_s  = buf_r;
        // RAM byte present now belongs to the address issued last cycle (k-1)
        final_buf_s[{k_dec_s, 3'b000} +: 8] = ram_din_i;
        read_data_s  = final_buf_s & size_mask(cnt_n_r);
    end

    // Stall while busy, and also in IDLE as soon as anyone is asking
    assign stall_o = (state_r != MC_IDLE) || if_req_i || mem_req_i;

    // Controller FSM; every RAM/result output is registered here
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_r     <= MC_IDLE;
            owner_mem_r <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            cnt_n_r     <= 3'd0;
            k_r         <= 3'd0;
            wdata_r     <= {DATA_W{1'b0}};
            buf_r       <= {DATA_W{1'b0}};
            if_data_o   <= {DATA_W{1'b0}};
            if_done_o   <= 1'b0;
            mem_rdata_o <= {DATA_W{1'b0}};
            mem_done_o  <= 1'b0;
            ram_dout_o  <= 8'h00;
            ram_a_o     <= {ADDR_W{1'b0}};
            ram_wr_o    <= 1'b0;
        end else begin
            // Results are only non-zero for the single DONE cycle
            if_data_o   <= {DATA_W{1'b0}};
            if_done_o   <= 1'b0;
            mem_rdata_o <= {DATA_W{1'b0}};
            mem_done_o  <= 1'b0;

            case (state_r)
                MC_IDLE: begin
                    k_r   <= 3'd0;
                    buf_r <= {DATA_W{1'b0}};
                    if (mem_req_i) begin
                        // MEM wins; a concurrent fetch simply stays pending
                        owner_mem_r <= 1'b1;
                        addr_r      <= mem_addr_i;
                        cnt_n_r     <= size_to_count(mem_sel_i);
                        wdata_r     <= mem_wdata_i;
                        ram_a_o     <= mem_addr_i;
                        if (mem_we_i) begin
                            state_r    <= MC_WRITE;
                            ram_wr_o   <= 1'b1;
                            ram_dout_o <= mem_wdata_i[7:0];
                        end else begin
                            state_r    <= MC_READ;
                            ram_wr_o   <= 1'b0;
                            ram_dout_o <= 8'h00;
                        end
                    end else if (if_req_i) begin
                        owner_mem_r <= 1'b0;
                        addr_r      <= if_addr_i;
                        cnt_n_r     <= 3'd4;
                        wdata_r     <= {DATA_W{1'b0}};
                        ram_a_o     <= if_addr_i;
                        ram_wr_o    <= 1'b0;
                        ram_dout_o  <= 8'h00;
                        state_r     <= MC_READ;
                    end else begin
                        ram_a_o    <= {ADDR_W{1'b0}};
                        ram_wr_o   <= 1'b0;
                        ram_dout_o <= 8'h00;
                    end
                end

                MC_READ: begin
                    ram_wr_o   <= 1'b0;
                    ram_dout_o <= 8'h00;
                    // Nothing has come back from the RAM yet in byte cycle 0
                    if (k_r != 3'd0) begin
                        buf_r <= final_buf_s;
                    end else begin
                        buf_r <= buf_r;
                    end
                    if (k_r == cnt_n_r) begin
                        // Trailing cycle: last byte is captured straight into the result
                        state_r <= MC_DONE;
                        ram_a_o <= {ADDR_W{1'b0}};
                        if (owner_mem_r) begin
                            mem_done_o  <= 1'b1;
                            mem_rdata_o <= read_data_s;
                        end else begin
                            if_done_o <= 1'b1;
                            if_data_o <= read_data_s;
                        end
                    end else begin
                        k_r <= k_inc_s;
                        // No address is driven in the trailing capture cycle
                        if (k_inc_s == cnt_n_r) begin
                            ram_a_o <= {ADDR_W{1'b0}};
                        end else begin
                            ram_a_o <= addr_next_s;
                        end
                    end
                end

                MC_WRITE: begin
                    if (k_inc_s == cnt_n_r) begin
                        state_r    <= MC_DONE;
                        ram_a_o    <= {ADDR_W{1'b0}};
                        ram_wr_o   <= 1'b0;
                        ram_dout_o <= 8'h00;
                        if (owner_mem_r) begin
                            mem_done_o <= 1'b1;
                        end else begin
                            if_done_o <= 1'b1;
                        end
                    end else begin
                        k_r        <= k_inc_s;
                        ram_a_o    <= addr_next_s;
                        ram_dout_o <= wbyte_next_s;
                        ram_wr_o   <= 1'b1;
                    end
                end

                MC_DONE: begin
                    // Requests are deliberately not sampled here
                    state_r    <= MC_IDLE;
                    ram_a_o    <= {ADDR_W{1'b0}};
                    ram_wr_o   <= 1'b0;
                    ram_dout_o <= 8'h00;
                end

                default: begin
                    state_r    <= MC_IDLE;
                    ram_a_o    <= {ADDR_W{1'b0}};
                    ram_wr_o   <= 1'b0;
                    ram_dout_o <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl
// Directed bench for mem_ctrl with a byte RAM model (one-cycle read latency).
// ---------------------------------------------------------------------------
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        stall;

    bit [7:0] ram [0:65535];

    int checks = 0;
    int errors = 0;

    mem_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_data_o   (if_data),
        .if_done_o   (if_done),
        .mem_req_i   (mem_req),
        .mem_we_i    (mem_we),
        .mem_sel_i   (mem_sel),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_rdata_o (mem_rdata),
        .mem_done_o  (mem_done),
        .ram_din_i   (ram_din),
        .ram_dout_o  (ram_dout),
        .ram_a_o     (ram_a),
        .ram_wr_o    (ram_wr),
        .stall_o     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte RAM: registered read, synchronous write, low 16 address bits
    always @(posedge clk) begin
        if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
        ram_din <= ram[ram_a[15:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        ram[16'h0100] <= 8'h13; ram[16'h0101] <= 8'h05;
        ram[16'h0102] <= 8'h10; ram[16'h0103] <= 8'h00;
        ram[16'h0200] <= 8'hEF; ram[16'h0201] <= 8'hBE;
        ram[16'h0202] <= 8'hAD; ram[16'h0203] <= 8'hDE;
        ram[16'h2000] <= 8'h44; ram[16'h2001] <= 8'h33;
        ram[16'h2002] <= 8'h22; ram[16'h2003] <= 8'h11;
        ram[16'hFFFF] <= 8'h80; ram[16'h0000] <= 8'h7F;

        rst = 1'b0; if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = 2'b00;
        mem_addr = 32'h0; mem_wdata = 32'h0;
        tick(); tick();
        chk("rst_ram_wr", {31'h0, ram_wr}, 32'h0);
        chk("rst_ram_a", ram_a, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_done", {30'h0, if_done, mem_done}, 32'h0);
        rst = 1'b1;
        tick();
        chk("idle_ram_a", ram_a, 32'h0);
        chk("idle_data", if_data | mem_rdata, 32'h0);

        // ---- Word fetch at 0x100 ----
        if_req = 1'b1; if_addr = 32'h0000_0100;
        #1;
        chk("fetch_pending_stall", {31'h0, stall}, 32'h1);
        tick();
        if_req = 1'b0;
        chk("fetch_a0", ram_a, 32'h100);
        chk("fetch_wr0", {31'h0, ram_wr}, 32'h0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("fetch_ak", ram_a, 32'h100 + 32'(k));
        end
        tick();
        chk("fetch_early_done", {31'h0, if_done}, 32'h0);
        tick();
        chk("fetch_done", {31'h0, if_done}, 32'h1);
        chk("fetch_data", if_data, 32'h0010_0513);
        chk("fetch_no_memdone", {31'h0, mem_done}, 32'h0);
        chk("fetch_done_ram_a", ram_a, 32'h0);
        tick();
        chk("fetch_done_drop", {31'h0, if_done}, 32'h0);
        chk("fetch_data_clear", if_data, 32'h0);
        chk("fetch_stall_clear", {31'h0, stall}, 32'h0);

        // ---- Conflict: MEM load word vs fetch ----
        if_req = 1'b1; if_addr = 32'h0000_0200;
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 2'b10; mem_addr = 32'h0000_2000;
        tick();
        mem_req = 1'b0;
        chk("conf_mem_first", ram_a, 32'h2000);
        repeat (5) tick();
        chk("conf_mem_done", {31'h0, mem_done}, 32'h1);
        chk("conf_mem_data", mem_rdata, 32'h1122_3344);
        chk("conf_no_ifdone", {31'h0, if_done}, 32'h0);
        tick();
        chk("conf_gap_ram_a", ram_a, 32'h0);
        chk("conf_gap_stall", {31'h0, stall}, 32'h1);
        chk("conf_gap_memdone", {31'h0, mem_done}, 32'h0);
        tick();
        if_req = 1'b0;
        chk("conf_fetch_a0", ram_a, 32'h200);
        repeat (5) tick();
        chk("conf_fetch_done", {31'h0, if_done}, 32'h1);
        chk("conf_fetch_data", if_data, 32'hDEAD_BEEF);
        tick();

        // ---- Store byte then halfword ----
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 2'b00;
        mem_addr = 32'h30; mem_wdata = 32'hAABB_CCDD;
        tick();
        mem_req = 1'b0;
        chk("sb_wr", {31'h0, ram_wr}, 32'h1);
        chk("sb_a", ram_a, 32'h30);
        chk("sb_dout", {24'h0, ram_dout}, 32'hDD);
        tick();
        chk("sb_wr_drop", {31'h0, ram_wr}, 32'h0);
        chk("sb_done", {31'h0, mem_done}, 32'h1);
        chk("sb_rdata_zero", mem_rdata, 32'h0);
        chk("sb_ram30", {24'h0, ram[16'h0030]}, 32'hDD);
        chk("sb_ram31", {24'h0, ram[16'h0031]}, 32'h00);
        tick();
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 2'b01;
        mem_addr = 32'h40; mem_wdata = 32'h5566_1234;
        tick();
        mem_req = 1'b0;
        chk("sh_wr0", {31'h0, ram_wr}, 32'h1);
        chk("sh_a0", ram_a, 32'h40);
        chk("sh_d0", {24'h0, ram_dout}, 32'h34);
        tick();
        chk("sh_wr1", {31'h0, ram_wr}, 32'h1);
        chk("sh_a1", ram_a, 32'h41);
        chk("sh_d1", {24'h0, ram_dout}, 32'h12);
        tick();
        chk("sh_wr_drop", {31'h0, ram_wr}, 32'h0);
        chk("sh_done", {31'h0, mem_done}, 32'h1);
        chk("sh_ram41", {24'h0, ram[16'h0041]}, 32'h12);
        chk("sh_ram42", {24'h0, ram[16'h0042]}, 32'h00);
        tick();

        // ---- Half load across the address wrap ----
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 2'b01; mem_addr = 32'hFFFF_FFFF;
        tick();
        mem_req = 1'b0;
        chk("wrap_a0", ram_a, 32'hFFFF_FFFF);
        tick();
        chk("wrap_a1", ram_a, 32'h0000_0000);
        tick();
        chk("wrap_early_done", {31'h0, mem_done}, 32'h0);
        tick();
        chk("wrap_done", {31'h0, mem_done}, 32'h1);
        chk("wrap_data", mem_rdata, 32'h0000_7F80);
        tick();

        // ---- Reset in the middle of a word store ----
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 2'b10;
        mem_addr = 32'h50; mem_wdata = 32'h0102_0304;
        tick();
        mem_req = 1'b0;
        tick();
        chk("rstmid_a1", ram_a, 32'h51);
        chk("rstmid_wr1", {31'h0, ram_wr}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_wr_async", {31'h0, ram_wr}, 32'h0);
        chk("rstmid_stall", {31'h0, stall}, 32'h0);
        chk("rstmid_a", ram_a, 32'h0);
        tick();
        chk("rstmid_no_done", {31'h0, mem_done}, 32'h0);
        chk("rstmid_ram50", {24'h0, ram[16'h0050]}, 32'h04);
        chk("rstmid_ram51", {24'h0, ram[16'h0051]}, 32'h00);
        rst = 1'b1;
        tick();
        chk("rstmid_idle_done", {31'h0, mem_done}, 32'h0);
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 2'b00; mem_addr = 32'h30;
        tick();
        mem_req = 1'b0;
        chk("post_rst_a", ram_a, 32'h30);
        tick(); tick();
        chk("post_rst_done", {31'h0, mem_done}, 32'h1);
        chk("post_rst_data", mem_rdata, 32'h0000_00DD);
        tick();

        // ---- Back-to-back loads with request held ----
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 2'b11; mem_addr = 32'h2000;
        tick();
        chk("b2b_a0", ram_a, 32'h2000);
        mem_addr = 32'h0000_0100;   // mid-access change must be ignored
        tick();
        chk("b2b_a1_ignored", ram_a, 32'h2001);
        repeat (4) tick();
        chk("b2b_done1", {31'h0, mem_done}, 32'h1);
        chk("b2b_data1", mem_rdata, 32'h1122_3344);
        mem_addr = 32'h0000_0200;
        tick();
        chk("b2b_gap_done", {31'h0, mem_done}, 32'h0);
        chk("b2b_gap_a", ram_a, 32'h0);
        tick();
        mem_req = 1'b0;
        chk("b2b_a2", ram_a, 32'h200);
        repeat (5) tick();
        chk("b2b_done2", {31'h0, mem_done}, 32'h1);
        chk("b2b_data2", mem_rdata, 32'hDEAD_BEEF);
        tick();
        chk("b2b_end_stall", {31'h0, stall}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
